mac_seq: RTL and testbench
==========================

# mac_seq

Operand sequencer that drives the control/data side of a `MAC` unit (`En`, `Clr`, `Ain`, `Bin`) and collects its `Cout`. It accepts a job start, pulses a clear, streams exactly DEPTH operand pairs from an upstream valid/ready source into the MAC, then captures the accumulated dot product and presents it on a valid/ready result port. It sits between the operand FIFOs and the MAC in the minilab datapath, one instance per MAC.

## Interface
- DATA_WIDTH, 8: operand width; accumulator width is 3*DATA_WIDTH.
- DEPTH, 8: operand pairs per job, 1..2^DATA_WIDTH.
- TIMEOUT, 255: idle-cycle limit in FEED; used only with MAC_SEQ_TIMEOUT_EN.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request, sampled only in IDLE.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  sequencer accepts pair this cycle.
- a_in, b_in  in  DATA_WIDTH each  operand pair.
- mac_en  out  1  to MAC `En`.
- mac_clr  out  1  to MAC `Clr`.
- mac_a, mac_b  out  DATA_WIDTH each  to MAC `Ain`/`Bin`.
- mac_cout  in  3*DATA_WIDTH  from MAC `Cout`.
- res_valid  out  1  result available.
- res_ready  in  1  downstream takes result.
- res_data  out  3*DATA_WIDTH  captured dot product.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle timeout pulse (tied 0 without macro).

## Operation
- Reset: state IDLE; in_ready, mac_en, mac_clr, res_valid, busy, err = 0; mac_a, mac_b, res_data = 0; beat counter = 0.
- All outputs registered except in_ready, which is decoded from state (high exactly in FEED).
- States IDLE, CLR, FEED, DRAIN, DONE.
- IDLE: start=1 -> CLR, mac_clr<=1. start outside IDLE is ignored.
- CLR: one cycle; -> FEED, mac_clr<=0.
- FEED: each edge with in_valid&in_ready: mac_a<=a_in, mac_b<=b_in, mac_en<=1, counter++; edges without handshake: mac_en<=0, operands hold. Handshake on beat DEPTH -> DRAIN, counter<=0.
- DRAIN: two cycles (1-bit sub-counter); mac_en<=0 on entry+1 edge; exit edge: res_data<=mac_cout, res_valid<=1 -> DONE.
- DONE: res_valid, res_data held until res_ready=1; on that edge res_valid<=0 -> IDLE. start in the same cycle is not accepted (one IDLE cycle minimum).
- mac_en and mac_clr never high together.
- Arithmetic is done in the MAC; the sequencer never modifies mac_cout; no saturation.

## Timing
- start accepted at edge s: mac_clr high cycle s..s+1; MAC clears at edge s+1; in_ready high from s+1.
- Pair accepted at edge t: mac_en/mac_a/mac_b valid t..t+1; MAC accumulates at edge t+1.
- Final pair accepted at edge t: res_valid high after edge t+2.
- Zero-stall job latency: start edge to res_valid = DEPTH+3 edges.
- Reset asserted mid-job: all outputs to reset values immediately (asynchronous); partial job discarded; MAC state is not relied upon (next job begins with CLR).

## Configuration
- MAC_SEQ_TIMEOUT_EN defined: idle counter increments each FEED cycle without handshake, clears on handshake; reaching TIMEOUT -> err<=1 for one cycle, mac_en<=0, counter cleared, state -> IDLE, no result produced.
- Undefined: no idle counter; FEED waits indefinitely; err constant 0.

## Structure
- mac_seq_pkg: state_t enum (IDLE, CLR, FEED, DRAIN, DONE). Widths stay local parameters (depend on DATA_WIDTH).
- No sub-module; the MAC is instantiated by the parent, not inside mac_seq.

## Test plan
- Reset held, then released with no start -> all outputs 0, busy 0, in_ready 0 for 10 cycles.
- DEPTH=4, start, four (2,2) pairs with in_valid constant -> mac_clr one cycle, mac_en four consecutive cycles, res_data=16, res_valid exactly 2 edges after 4th accept.
- Same job with in_valid low every other cycle -> mac_en only after accepted beats, res_data=16.
- Hold res_ready low 5 cycles -> res_valid/res_data stable, in_ready 0, start ignored; then job of four (255,255) -> res_data=260100 (0x03F804), proving clear between jobs.
- Assert rst_n low after 2nd accepted beat -> outputs 0 same cycle; next job of four (3,1) -> res_data=12.
- With MAC_SEQ_TIMEOUT_EN, TIMEOUT=8: stall in_valid 8 cycles in FEED -> err one-cycle pulse, busy 0, res_valid never asserted.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types for the MAC operand sequencer.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FEED,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mac_seq.sv
// Operand sequencer for one MAC: clear, stream DEPTH pairs, capture Cout, hand off result.
// Optional FEED stall timeout enabled by defining MAC_SEQ_TIMEOUT_EN.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     a_in,
    input  logic [DATA_WIDTH-1:0]     b_in,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic [DATA_WIDTH-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]     mac_b,
    input  logic [3*DATA_WIDTH-1:0]   mac_cout,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [3*DATA_WIDTH-1:0]   res_data,
    output logic                      busy,
    output logic                      err
);

    localparam int unsigned ACC_W = 3 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             drain_cnt;

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    logic [IDLE_W-1:0] idle_cnt;
`else
    assign err = 1'b0;
`endif

    // Only FEED takes operands; decoded straight from state so the handshake has no bubble.
    assign in_ready = (state == FEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= 1'b0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= ACC_W'(0);
            busy      <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            idle_cnt  <= '0;
            err       <= 1'b0;
`endif
        end else begin
`ifdef MAC_SEQ_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLR;
                        mac_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLR: begin
                    mac_clr <= 1'b0;
                    state   <= FEED;
                end
                FEED: begin
                    if (in_valid) begin
                        mac_a  <= a_in;
                        mac_b  <= b_in;
                        mac_en <= 1'b1;
`ifdef MAC_SEQ_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt  <= '0;
                            drain_cnt <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else begin
                        mac_en <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
                        // Abandon the job when upstream stalls too long; no result is produced.
                        if (idle_cnt == IDLE_LAST) begin
                            err      <= 1'b1;
                            idle_cnt <= '0;
                            beat_cnt <= '0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
`endif
                    end
                end
                DRAIN: begin
                    // Second edge lets the MAC fold in the final pair before Cout is captured.
                    mac_en <= 1'b0;
                    if (drain_cnt) begin
                        drain_cnt <= 1'b0;
                        res_data  <= mac_cout;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq with a behavioural MAC; define MAC_SEQ_TIMEOUT_EN to exercise the stall timeout.
module tb_mac_seq;

    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int TO  = 8;
    localparam int AW  = 3 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          mac_en;
    logic          mac_clr;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [AW-1:0] mac_cout;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;
    logic          busy;
    logic          err;

    mac_seq #(.DATA_WIDTH(DW), .DEPTH(DEP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cout(mac_cout), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: no reset, so a skipped clear leaves stale partial sums visible.
    logic [AW-1:0] acc = '0;
    always @(posedge clk) begin
        if (mac_clr)     acc <= '0;
        else if (mac_en) acc <= acc + AW'(mac_a) * AW'(mac_b);
    end
    assign mac_cout = acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic hs_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_q <= 1'b0;
        else        hs_q <= in_valid && in_ready;
    end

    int checks = 0;
    int errors = 0;
    int en_total = 0, en_run = 0, en_last_run = 0, clr_total = 0;
    logic [AW-1:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop on result handshake plus per-cycle control invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            check("en_clr_exclusive", longint'(mac_en && mac_clr), 0);
            check("en_follows_accept", longint'(mac_en), longint'(hs_q));
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", longint'(res_data), -1);
                else check("res_data", longint'(res_data), longint'(exp_q.pop_front()));
            end
        end
        if (mac_en) begin
            en_total++;
            en_run++;
        end else if (en_run != 0) begin
            en_last_run = en_run;
            en_run = 0;
        end
        if (mac_clr) clr_total++;
    end

    function automatic longint outs_vec();
        return longint'({in_ready, mac_en, mac_clr, res_valid, busy, err, mac_a, mac_b, res_data});
    endfunction

    task automatic do_start(output int s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic feed_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, output int t);
        int n = 0;
        a_in = a; b_in = b; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        t = cyc;
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [DW-1:0] av [4], input logic [DW-1:0] bv [4],
                           input bit gaps, input int hold, input longint exp, input bit chk_lat);
        int s, t, n, en0, clr0;
        en0 = en_total; clr0 = clr_total;
        exp_q.push_back(AW'(exp));
        do_start(s);
        check("clr_after_start", longint'(mac_clr), 1);
        check("busy_after_start", longint'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) begin
                @(posedge clk); #1;
            end
            feed_beat(av[i], bv[i], t);
        end
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_valid_seen", longint'(res_valid), 1);
        check("last_accept_to_valid", cyc - t, 2);
        if (chk_lat) check("start_to_valid", cyc - s, DEP + 3);
        check("mac_en_count", en_total - en0, 4);
        check("mac_en_run", en_last_run, gaps ? 1 : 4);
        check("mac_clr_count", clr_total - clr0, 1);
        start = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", longint'(res_valid), 1);
            check("hold_data", longint'(res_data), exp);
            check("hold_in_ready", longint'(in_ready), 0);
            check("hold_busy", longint'(busy), 1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start = 1'b0;
        check("valid_dropped", longint'(res_valid), 0);
        check("idle_after_take", longint'(busy), 0);
        check("no_clr_after_take", longint'(mac_clr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, t, n;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_outputs", outs_vec(), 0);
        end
        @(posedge clk); #1;

        run_job('{8'd2, 8'd2, 8'd2, 8'd2}, '{8'd2, 8'd2, 8'd2, 8'd2}, 1'b0, 0, 16, 1'b1);
        run_job('{8'd2, 8'd2, 8'd2, 8'd2}, '{8'd2, 8'd2, 8'd2, 8'd2}, 1'b1, 5, 16, 1'b0);
        run_job('{8'd255, 8'd255, 8'd255, 8'd255}, '{8'd255, 8'd255, 8'd255, 8'd255}, 1'b0, 0, 260100, 1'b1);
        run_job('{8'd1, 8'd3, 8'd5, 8'd7}, '{8'd2, 8'd4, 8'd6, 8'd8}, 1'b0, 1, 100, 1'b1);

        // Abort a job after two accepted beats; the next job must still start from a clean MAC.
        @(posedge clk); #1;
        do_start(s);
        feed_beat(8'd2, 8'd2, t);
        feed_beat(8'd2, 8'd2, t);
        rst_n = 1'b0;
        #1 check("async_reset_outputs", outs_vec(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_reset_outputs", outs_vec(), 0);
        @(posedge clk); #1;
        run_job('{8'd3, 8'd3, 8'd3, 8'd3}, '{8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 0, 12, 1'b1);

`ifdef MAC_SEQ_TIMEOUT_EN
        @(posedge clk); #1;
        do_start(s);
        n = 0;
        while (!err && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_err", longint'(err), 1);
        check("timeout_cycle", cyc - s, TO + 1);
        check("timeout_busy", longint'(busy), 0);
        check("timeout_in_ready", longint'(in_ready), 0);
        @(posedge clk); #1;
        check("err_one_cycle", longint'(err), 0);
        repeat (4) begin
            @(negedge clk);
            check("timeout_no_result", longint'(res_valid), 0);
        end
`endif

        repeat (3) @(posedge clk);
        #1 check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
